lsu_arbiter: RTL and testbench
==============================

Name: lsu_arbiter

Overview:
Two-port arbiter that shares the single load/store unit between the CPU datapath (port 0) and a secondary master (port 1: boot loader / debug / DMA).
- Accepts one request at a time via valid/ready handshake.
- Drives the LSU address, store data and write-enable for exactly one cycle per transaction.
- Captures the LSU's combinational load data and returns a one-cycle response to the requester that owned the transaction.
- Port 0 has fixed priority, bounded by an anti-starvation counter for port 1.

Parameters:
ADDR_W, 32, address width to LSU
DATA_W, 32, data width
MAX_WAIT, 4, consecutive lost arbitration cycles after which port 1 is forced to win (1..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_p0_valid  in  1  port 0 request valid
i_p0_addr  in  ADDR_W  port 0 address
i_p0_wdata  in  DATA_W  port 0 store data
i_p0_wren  in  1  port 0 1=store, 0=load
o_p0_ready  out  1  port 0 request accepted this cycle
o_p0_rsp_valid  out  1  port 0 response pulse
o_p0_rdata  out  DATA_W  port 0 load data
i_p1_valid, i_p1_addr, i_p1_wdata, i_p1_wren, o_p1_ready, o_p1_rsp_valid, o_p1_rdata: same widths/meaning for port 1
o_lsu_addr  out  ADDR_W  to LSU i_lsu_addr
o_lsu_st_data  out  DATA_W  to LSU i_st_data
o_lsu_wren  out  1  to LSU i_lsu_wren
o_lsu_busy  out  1  high while a transaction is driven to LSU
i_lsu_ld_data  in  DATA_W  from LSU o_ld_data (combinational on o_lsu_addr)

Behaviour:
- Reset (async, i_rst=1): state IDLE, starvation counter 0, all outputs 0, captured request registers 0. Reset mid-ISSUE aborts the transaction: no write is completed and no response pulse is issued.
- FSM states: IDLE, ISSUE.
- IDLE:
  - Winner selection: port 1 if (i_p1_valid and starve_cnt==MAX_WAIT) or (i_p1_valid and !i_p0_valid); else port 0 if i_p0_valid; else none.
  - o_pX_ready is combinational: 1 only for the winner; at most one ready high per cycle.
  - On handshake (valid & ready), register addr, wdata, wren and owner id, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - o_lsu_busy=1; o_lsu_addr, o_lsu_st_data and o_lsu_wren are driven from the registered request.
  - At the clock edge ending ISSUE, sample i_lsu_ld_data into the owner's rdata register (0 for stores), then return to IDLE.
  - Both ready outputs are 0 during ISSUE.
- Outside ISSUE: o_lsu_wren=0, o_lsu_addr=0, o_lsu_st_data=0. A store must never reach the LSU except during ISSUE.
- Response: o_pX_rsp_valid pulses high for 1 cycle, in the cycle after ISSUE, for the owner only (loads and stores). o_pX_rdata holds its value until that port's next response.
- Latency: handshake in cycle N, LSU access in N+1, rsp_valid in N+2. Max throughput is 1 transaction per 2 cycles. A new handshake is allowed in the same cycle as the rsp_valid of the previous transaction.
- Starvation counter (4 bits, saturating at MAX_WAIT):
  - Increments on each IDLE cycle where i_p1_valid=1 and port 0 wins.
  - Clears when port 1 wins or when i_p1_valid=0 in IDLE.
  - Holds during ISSUE.
- Requester rule: valid, addr, wdata and wren stay stable until ready. The arbiter does not check this. A request dropped before ready is simply not served.
- Both ports may request the same address; they are serialized in grant order with no hazard logic.

Test Plan:
- Port 0 load: i_p0_valid=1, addr=32'h2004, wren=0, LSU returns 32'hDEADBEEF → o_p0_ready in cycle 0; o_lsu_busy=1 and o_lsu_addr=32'h2004 in cycle 1; o_p0_rsp_valid=1 and o_p0_rdata=32'hDEADBEEF in cycle 2; port 1 outputs stay 0.
- Port 1 store: addr=32'h7000, wdata=32'h5A5A5A5A, wren=1 → o_lsu_wren=1 for exactly one cycle with that address and data; o_p1_rsp_valid pulse with o_p1_rdata=0.
- Simultaneous single requests (p0 load 32'h2000, p1 load 32'h2008) → p0 granted first, p1 granted in the cycle of p0's rsp_valid; two LSU accesses in order 2000, 2008.
- Starvation, MAX_WAIT=4: p0 valid continuously, p1 valid from cycle 0 → p0 wins 4 arbitrations, p1 wins the 5th; counter returns to 0 afterwards.
- Async reset asserted during ISSUE of a store → o_lsu_wren drops to 0 immediately; no rsp_valid; after reset release, ready reappears for a pending valid.
- Idle bus: no valid for 20 cycles → o_lsu_busy, o_lsu_wren and both ready signals remain 0.

Source files
------------

// File: rtl/lsu_arbiter_if.sv
// Bundle of the two requester ports and the LSU-facing bus used by lsu_arbiter.
// The slave modport is the arbiter's view; master is the requesters/LSU side.
interface lsu_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_p0_valid;
  logic [ADDR_W-1:0] i_p0_addr;
  logic [DATA_W-1:0] i_p0_wdata;
  logic              i_p0_wren;
  logic              o_p0_ready;
  logic              o_p0_rsp_valid;
  logic [DATA_W-1:0] o_p0_rdata;

  logic              i_p1_valid;
  logic [ADDR_W-1:0] i_p1_addr;
  logic [DATA_W-1:0] i_p1_wdata;
  logic              i_p1_wren;
  logic              o_p1_ready;
  logic              o_p1_rsp_valid;
  logic [DATA_W-1:0] o_p1_rdata;

  logic [ADDR_W-1:0] o_lsu_addr;
  logic [DATA_W-1:0] o_lsu_st_data;
  logic              o_lsu_wren;
  logic              o_lsu_busy;
  logic [DATA_W-1:0] i_lsu_ld_data;

  modport slave (
    input  i_p0_valid, i_p0_addr, i_p0_wdata, i_p0_wren,
    output o_p0_ready, o_p0_rsp_valid, o_p0_rdata,
    input  i_p1_valid, i_p1_addr, i_p1_wdata, i_p1_wren,
    output o_p1_ready, o_p1_rsp_valid, o_p1_rdata,
    output o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_busy,
    input  i_lsu_ld_data
  );

  modport master (
    output i_p0_valid, i_p0_addr, i_p0_wdata, i_p0_wren,
    input  o_p0_ready, o_p0_rsp_valid, o_p0_rdata,
    output i_p1_valid, i_p1_addr, i_p1_wdata, i_p1_wren,
    input  o_p1_ready, o_p1_rsp_valid, o_p1_rdata,
    input  o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_busy,
    output i_lsu_ld_data
  );
endinterface

// File: rtl/lsu_arbiter.sv
// Shares one load/store unit between the CPU (port 0, priority) and a secondary
// master (port 1), with an anti-starvation counter that eventually forces port 1 in.
module lsu_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  lsu_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ISSUE} state_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        starveCnt_q, starveCnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wren_q, wren_d;
  logic              owner_q, owner_d;
  logic              rsp0_q, rsp0_d;
  logic              rsp1_q, rsp1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              p0Win, p1Win;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      owner_q     <= 1'b0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      owner_q     <= owner_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Ready is gated by reset so that every output reads 0 while reset is held.
  always_comb begin
    state_d           = state_q;
    starveCnt_d       = starveCnt_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    wren_d            = wren_q;
    owner_d           = owner_q;
    rsp0_d            = 1'b0;
    rsp1_d            = 1'b0;
    rdata0_d          = rdata0_q;
    rdata1_d          = rdata1_q;
    p0Win             = 1'b0;
    p1Win             = 1'b0;
    bus.o_p0_ready    = 1'b0;
    bus.o_p1_ready    = 1'b0;
    bus.o_lsu_busy    = 1'b0;
    bus.o_lsu_addr    = '0;
    bus.o_lsu_st_data = '0;
    bus.o_lsu_wren    = 1'b0;

    case (state_q)
      IDLE: begin
        p1Win          = bus.i_p1_valid && ((starveCnt_q == MaxWait) || !bus.i_p0_valid);
        p0Win          = bus.i_p0_valid && !p1Win;
        bus.o_p0_ready = p0Win && !i_rst;
        bus.o_p1_ready = p1Win && !i_rst;
        if (p1Win) begin
          addr_d      = bus.i_p1_addr;
          wdata_d     = bus.i_p1_wdata;
          wren_d      = bus.i_p1_wren;
          owner_d     = 1'b1;
          starveCnt_d = '0;
          state_d     = ISSUE;
        end else if (p0Win) begin
          addr_d  = bus.i_p0_addr;
          wdata_d = bus.i_p0_wdata;
          wren_d  = bus.i_p0_wren;
          owner_d = 1'b0;
          state_d = ISSUE;
          if (bus.i_p1_valid && (starveCnt_q < MaxWait)) begin
            starveCnt_d = starveCnt_q + 4'd1;
          end
        end
        if (!bus.i_p1_valid) begin
          starveCnt_d = '0;
        end
      end
      ISSUE: begin
        bus.o_lsu_busy    = 1'b1;
        bus.o_lsu_addr    = addr_q;
        bus.o_lsu_st_data = wdata_q;
        bus.o_lsu_wren    = wren_q;
        if (owner_q) begin
          rsp1_d   = 1'b1;
          rdata1_d = wren_q ? '0 : bus.i_lsu_ld_data;
        end else begin
          rsp0_d   = 1'b1;
          rdata0_d = wren_q ? '0 : bus.i_lsu_ld_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_p0_rsp_valid = rsp0_q;
  assign bus.o_p1_rsp_valid = rsp1_q;
  assign bus.o_p0_rdata     = rdata0_q;
  assign bus.o_p1_rdata     = rdata1_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: a per-cycle vector table for the basic flows,
// plus hand-written sequences for starvation, reset during ISSUE and an idle bus.
module tb_lsu_arbiter;

  typedef struct {
    logic        p0V;
    logic [31:0] p0A;
    logic [31:0] p0D;
    logic        p0W;
    logic        p1V;
    logic [31:0] p1A;
    logic [31:0] p1D;
    logic        p1W;
    logic        eR0;
    logic        eR1;
    logic        eBusy;
    logic [31:0] eAddr;
    logic [31:0] eData;
    logic        eWren;
    logic        eRsp0;
    logic [31:0] eRd0;
    logic        eRsp1;
    logic [31:0] eRd1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  vec_t vecs[16];

  lsu_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // LSU model: one recognisable word at 0x2004, otherwise address-derived data.
  assign bus.i_lsu_ld_data = (bus.o_lsu_addr == 32'h2004) ? 32'hDEADBEEF
                                                          : (bus.o_lsu_addr ^ 32'hA5A5_0000);

  task automatic expectEq(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic driveInputs(input logic p0V, input logic [31:0] p0A, input logic [31:0] p0D,
                             input logic p0W, input logic p1V, input logic [31:0] p1A,
                             input logic [31:0] p1D, input logic p1W);
    bus.i_p0_valid = p0V;
    bus.i_p0_addr  = p0A;
    bus.i_p0_wdata = p0D;
    bus.i_p0_wren  = p0W;
    bus.i_p1_valid = p1V;
    bus.i_p1_addr  = p1A;
    bus.i_p1_wdata = p1D;
    bus.i_p1_wren  = p1W;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    driveInputs(v.p0V, v.p0A, v.p0D, v.p0W, v.p1V, v.p1A, v.p1D, v.p1W);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    #4;
    expectEq($sformatf("vec%0d p0_ready", idx), 32'(bus.o_p0_ready), 32'(v.eR0));
    expectEq($sformatf("vec%0d p1_ready", idx), 32'(bus.o_p1_ready), 32'(v.eR1));
    expectEq($sformatf("vec%0d lsu_busy", idx), 32'(bus.o_lsu_busy), 32'(v.eBusy));
    expectEq($sformatf("vec%0d lsu_addr", idx), bus.o_lsu_addr, v.eAddr);
    expectEq($sformatf("vec%0d lsu_st_data", idx), bus.o_lsu_st_data, v.eData);
    expectEq($sformatf("vec%0d lsu_wren", idx), 32'(bus.o_lsu_wren), 32'(v.eWren));
    expectEq($sformatf("vec%0d p0_rsp_valid", idx), 32'(bus.o_p0_rsp_valid), 32'(v.eRsp0));
    expectEq($sformatf("vec%0d p0_rdata", idx), bus.o_p0_rdata, v.eRd0);
    expectEq($sformatf("vec%0d p1_rsp_valid", idx), 32'(bus.o_p1_rsp_valid), 32'(v.eRsp1));
    expectEq($sformatf("vec%0d p1_rdata", idx), bus.o_p1_rdata, v.eRd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0Grants;
    int p1Grants;
    int p0BeforeFirst;
    int p0Between;
    int bothHigh;

    // p0 load 0x2004, p1 store 0x7000, simultaneous loads 0x2000/0x2008, p1 store 0x7004
    vecs[0]  = '{1'b1, 32'h2004, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7000, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7000, 32'h5A5A5A5A, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h2000, 32'h0, 1'b0, 1'b1, 32'h2008, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2008, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2008, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA5A52000, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2008, 32'h0, 1'b0, 1'b0, 32'hA5A52000, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A52000, 1'b1, 32'hA5A52008};
    vecs[12] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A52000, 1'b0, 32'hA5A52008};
    vecs[13] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7004, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A52000, 1'b0, 32'hA5A52008};
    vecs[14] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7004, 32'h1, 1'b1, 1'b0, 32'hA5A52000, 1'b0, 32'hA5A52008};
    vecs[15] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A52000, 1'b1, 32'h0};

    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #5;
    expectEq("reset p0_ready", 32'(bus.o_p0_ready), 32'h0);
    expectEq("reset p1_ready", 32'(bus.o_p1_ready), 32'h0);
    expectEq("reset lsu_busy", 32'(bus.o_lsu_busy), 32'h0);
    expectEq("reset lsu_wren", 32'(bus.o_lsu_wren), 32'h0);
    expectEq("reset lsu_addr", bus.o_lsu_addr, 32'h0);
    expectEq("reset p0_rsp_valid", 32'(bus.o_p0_rsp_valid), 32'h0);
    expectEq("reset p1_rsp_valid", 32'(bus.o_p1_rsp_valid), 32'h0);
    expectEq("reset p0_rdata", bus.o_p0_rdata, 32'h0);
    expectEq("reset p1_rdata", bus.o_p1_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Starvation: both ports request continuously; port 1 gets every 5th grant.
    p0Grants = 0;
    p1Grants = 0;
    p0BeforeFirst = -1;
    p0Between = -1;
    bothHigh = 0;
    for (int cyc = 0; cyc < 40 && p1Grants < 2; cyc++) begin
      @(posedge clk);
      #1;
      driveInputs(1'b1, 32'h3000, 32'h0, 1'b0, 1'b1, 32'h4000, 32'h0, 1'b0);
      #4;
      if (bus.o_p0_ready && bus.o_p1_ready) bothHigh++;
      if (bus.o_p0_ready) p0Grants++;
      if (bus.o_p1_ready) begin
        p1Grants++;
        if (p1Grants == 1) p0BeforeFirst = p0Grants;
        else p0Between = p0Grants - p0BeforeFirst;
      end
    end
    expectEq("starve p1 grants seen", 32'(p1Grants), 32'd2);
    expectEq("starve p0 wins before 1st p1", 32'(p0BeforeFirst), 32'd4);
    expectEq("starve p0 wins before 2nd p1", 32'(p0Between), 32'd4);
    expectEq("starve ready exclusive", 32'(bothHigh), 32'd0);
    @(posedge clk);
    #1;
    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);

    // Async reset while a port 0 store is on the LSU bus.
    #1;
    driveInputs(1'b1, 32'h5000, 32'h11112222, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    #4;
    expectEq("rstmid handshake ready", 32'(bus.o_p0_ready), 32'h1);
    @(posedge clk);
    #2;
    expectEq("rstmid wren before reset", 32'(bus.o_lsu_wren), 32'h1);
    expectEq("rstmid addr before reset", bus.o_lsu_addr, 32'h5000);
    rst = 1'b1;
    #1;
    expectEq("rstmid wren after reset", 32'(bus.o_lsu_wren), 32'h0);
    expectEq("rstmid busy after reset", 32'(bus.o_lsu_busy), 32'h0);
    expectEq("rstmid addr after reset", bus.o_lsu_addr, 32'h0);
    @(posedge clk);
    #4;
    expectEq("rstmid no rsp during reset", 32'(bus.o_p0_rsp_valid), 32'h0);
    rst = 1'b0;
    #1;
    expectEq("rstmid ready after release", 32'(bus.o_p0_ready), 32'h1);
    expectEq("rstmid no rsp after release", 32'(bus.o_p0_rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #4;
    expectEq("rstmid reissue wren", 32'(bus.o_lsu_wren), 32'h1);
    @(posedge clk);
    #5;
    expectEq("rstmid reissue rsp", 32'(bus.o_p0_rsp_valid), 32'h1);
    expectEq("rstmid reissue rdata", bus.o_p0_rdata, 32'h0);

    // Idle bus: nothing may move.
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #5;
      expectEq($sformatf("idle cyc%0d busy/wren/ready", cyc),
               {28'h0, bus.o_lsu_busy, bus.o_lsu_wren, bus.o_p0_ready, bus.o_p1_ready}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
